// File: rtl/dmem_stall_responder.sv
// dmem_stall_responder
// Multi-cycle data-memory responder for the M stage. A load or store is
// captured when it is accepted in IDLE, waited out for LATENCY cycles, committed
// on the edge into DONE, and reported with a single-cycle MemDoneM pulse.
// MemBusyM stalls the pipeline from acceptance until the DONE cycle.
module dmem_stall_responder #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2,
  parameter int AW      = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic [3:0]  WriteStrbM,
  output logic [31:0] ReadDataM,
  output logic        MemBusyM,
  output logic        MemDoneM
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [3:0] LAT = 4'(LATENCY);

  logic [1:0]    state_q, state_d;
  logic [3:0]    count_q, count_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    strb_q, strb_d;
  logic          is_store_q, is_store_d;
  logic [31:0]   rdata_q, rdata_d;

  logic          req;
  logic [AW-1:0] in_idx;

  logic          commit;
  logic [AW-1:0] c_idx;
  logic [31:0]   c_data;
  logic [3:0]    c_strb;
  logic          c_store;

  logic [31:0]   mem [DEPTH];

  // Byte-offset bits and address bits above the array are deliberately dropped.
  logic          unused_addr_bits;

  assign req              = MemReadM | MemWriteM;
  assign in_idx           = ALUResultM[AW+1:2];
  assign unused_addr_bits = ^{ALUResultM[31:AW+2], ALUResultM[1:0]};

  // FSM next state, request capture and selection of the access to commit.
  // With zero latency the access is taken straight from the live inputs on the
  // accepting edge, because the capture registers are only loaded on that edge.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    strb_d     = strb_q;
    is_store_d = is_store_q;
    commit     = 1'b0;
    c_idx      = addr_q;
    c_data     = wdata_q;
    c_strb     = strb_q;
    c_store    = is_store_q;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          addr_d     = in_idx;
          wdata_d    = WriteDataM;
          strb_d     = WriteStrbM;
          is_store_d = MemWriteM;
          count_d    = LAT;
          if (LATENCY == 0) begin
            state_d = ST_DONE;
            commit  = 1'b1;
            c_idx   = in_idx;
            c_data  = WriteDataM;
            c_strb  = WriteStrbM;
            c_store = MemWriteM;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        count_d = count_q - 4'd1;
        if (count_q == 4'd1) begin
          commit  = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Load data is registered only when a load commits; otherwise it holds.
  always_comb begin
    rdata_d = rdata_q;
    if (commit && !c_store) begin
      rdata_d = mem[c_idx];
    end
  end

  // Control and captured-request registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      count_q    <= 4'd0;
      addr_q     <= '0;
      wdata_q    <= 32'd0;
      strb_q     <= 4'd0;
      is_store_q <= 1'b0;
      rdata_q    <= 32'd0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      strb_q     <= strb_d;
      is_store_q <= is_store_d;
      rdata_q    <= rdata_d;
    end
  end

  // Storage array: byte-strobed write on commit; reset blocks a pending write.
  always_ff @(posedge clk) begin
    if (!reset && commit && c_store) begin
      for (int b = 0; b < 4; b++) begin
        if (c_strb[b]) begin
          mem[c_idx][8*b +: 8] <= c_data[8*b +: 8];
        end
      end
    end
  end

  assign MemBusyM  = ((state_q == ST_IDLE) && req) || (state_q == ST_WAIT);
  assign MemDoneM  = (state_q == ST_DONE);
  assign ReadDataM = rdata_q;

endmodule

// File: tb/tb_dmem_stall_responder.sv
// tb_dmem_stall_responder
// Directed bench for dmem_stall_responder. Three instances cover LATENCY=2
// (main behaviour), LATENCY=0 (single-cycle stall and no retrigger) and
// LATENCY=3 (reset in the middle of a wait). Inputs change on the falling
// edge and outputs are sampled 1 ns later.
module tb_dmem_stall_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst2, rd2, wr2, busy2, done2;
  logic [31:0] addr2, wdata2, rdata2;
  logic [3:0]  strb2;

  logic        rst0, rd0, wr0, busy0, done0;
  logic [31:0] addr0, wdata0, rdata0;
  logic [3:0]  strb0;

  logic        rst3, rd3, wr3, busy3, done3;
  logic [31:0] addr3, wdata3, rdata3;
  logic [3:0]  strb3;

  int errors = 0;
  int checks = 0;

  int          dc, bc;
  logic [31:0] rv;
  logic        bd;

  dmem_stall_responder #(.DEPTH(1024), .LATENCY(2)) u_l2 (
    .clk(clk), .reset(rst2), .MemReadM(rd2), .MemWriteM(wr2),
    .ALUResultM(addr2), .WriteDataM(wdata2), .WriteStrbM(strb2),
    .ReadDataM(rdata2), .MemBusyM(busy2), .MemDoneM(done2)
  );

  dmem_stall_responder #(.DEPTH(1024), .LATENCY(0)) u_l0 (
    .clk(clk), .reset(rst0), .MemReadM(rd0), .MemWriteM(wr0),
    .ALUResultM(addr0), .WriteDataM(wdata0), .WriteStrbM(strb0),
    .ReadDataM(rdata0), .MemBusyM(busy0), .MemDoneM(done0)
  );

  dmem_stall_responder #(.DEPTH(1024), .LATENCY(3)) u_l3 (
    .clk(clk), .reset(rst3), .MemReadM(rd3), .MemWriteM(wr3),
    .ALUResultM(addr3), .WriteDataM(wdata3), .WriteStrbM(strb3),
    .ReadDataM(rdata3), .MemBusyM(busy3), .MemDoneM(done3)
  );

  task automatic drive(input int inst, input logic rd, input logic wr,
                       input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    case (inst)
      0: begin rd0 = rd; wr0 = wr; addr0 = a; wdata0 = d; strb0 = s; end
      2: begin rd2 = rd; wr2 = wr; addr2 = a; wdata2 = d; strb2 = s; end
      default: begin rd3 = rd; wr3 = wr; addr3 = a; wdata3 = d; strb3 = s; end
    endcase
  endtask

  task automatic sample(input int inst, output logic b, output logic dn, output logic [31:0] r);
    case (inst)
      0: begin b = busy0; dn = done0; r = rdata0; end
      2: begin b = busy2; dn = done2; r = rdata2; end
      default: begin b = busy3; dn = done3; r = rdata3; end
    endcase
  endtask

  // One access held until MemDoneM (bounded to 20 cycles); reports the cycle of
  // the done pulse (0 if never seen), stall cycles, and outputs in that cycle.
  task automatic run(input int inst, input logic rd, input logic wr,
                     input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                     output int done_cyc, output int busy_cnt,
                     output logic [31:0] rdata_done, output logic busy_done);
    logic        b, dn;
    logic [31:0] r;
    done_cyc   = 0;
    busy_cnt   = 0;
    rdata_done = 32'd0;
    busy_done  = 1'b1;
    @(negedge clk);
    drive(inst, rd, wr, a, d, s);
    for (int c = 1; c <= 20; c++) begin
      #1;
      sample(inst, b, dn, r);
      if (b) busy_cnt++;
      if (dn) begin
        done_cyc   = c;
        rdata_done = r;
        busy_done  = b;
        break;
      end
      @(negedge clk);
    end
    drive(inst, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst2 = 1'b1; rst0 = 1'b1; rst3 = 1'b1;
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    drive(2, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    drive(3, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst2 = 1'b0; rst0 = 1'b0; rst3 = 1'b0;
    #1;
    checks++; if (busy2 !== 1'b0) begin errors++; $display("FAIL reset_busy2 got=%b exp=0", busy2); end
    checks++; if (done2 !== 1'b0) begin errors++; $display("FAIL reset_done2 got=%b exp=0", done2); end
    checks++; if (rdata2 !== 32'd0) begin errors++; $display("FAIL reset_rdata2 got=%h exp=0", rdata2); end
    checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL reset_done0 got=%b exp=0", done0); end
    checks++; if (rdata3 !== 32'd0) begin errors++; $display("FAIL reset_rdata3 got=%h exp=0", rdata3); end
  endtask

  task automatic test_store_load();
    run(2, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, dc, bc, rv, bd);
    checks++; if (dc != 4) begin errors++; $display("FAIL store_done_cycle got=%0d exp=4", dc); end
    checks++; if (bc != 3) begin errors++; $display("FAIL store_busy_cycles got=%0d exp=3", bc); end
    checks++; if (bd !== 1'b0) begin errors++; $display("FAIL store_busy_in_done got=%b exp=0", bd); end
    run(2, 1'b1, 1'b0, 32'h10, 32'd0, 4'd0, dc, bc, rv, bd);
    checks++; if (dc != 4) begin errors++; $display("FAIL load_done_cycle got=%0d exp=4", dc); end
    checks++; if (rv !== 32'hDEADBEEF) begin errors++; $display("FAIL load_data got=%h exp=deadbeef", rv); end
    checks++; if (bd !== 1'b0) begin errors++; $display("FAIL load_busy_in_done got=%b exp=0", bd); end
    #1;
    checks++; if (rdata2 !== 32'hDEADBEEF) begin errors++; $display("FAIL load_data_hold got=%h exp=deadbeef", rdata2); end
  endtask

  task automatic test_byte_strobes();
    run(2, 1'b0, 1'b1, 32'h20, 32'h11223344, 4'hF, dc, bc, rv, bd);
    run(2, 1'b0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, dc, bc, rv, bd);
    run(2, 1'b1, 1'b0, 32'h20, 32'd0, 4'd0, dc, bc, rv, bd);
    checks++; if (rv !== 32'h11BB33DD) begin errors++; $display("FAIL strobe_merge got=%h exp=11bb33dd", rv); end
  endtask

  task automatic test_zero_strobe();
    run(2, 1'b0, 1'b1, 32'h10, 32'h0, 4'h0, dc, bc, rv, bd);
    checks++; if (dc != 4) begin errors++; $display("FAIL zero_strb_done_cycle got=%0d exp=4", dc); end
    run(2, 1'b1, 1'b0, 32'h10, 32'd0, 4'd0, dc, bc, rv, bd);
    checks++; if (rv !== 32'hDEADBEEF) begin errors++; $display("FAIL zero_strb_unchanged got=%h exp=deadbeef", rv); end
  endtask

  task automatic test_wrap();
    run(2, 1'b0, 1'b1, 32'h1003, 32'h5, 4'hF, dc, bc, rv, bd);
    run(2, 1'b1, 1'b0, 32'h0, 32'd0, 4'd0, dc, bc, rv, bd);
    checks++; if (rv !== 32'h5) begin errors++; $display("FAIL wrap_index0 got=%h exp=5", rv); end
    run(2, 1'b1, 1'b0, 32'h2002, 32'd0, 4'd0, dc, bc, rv, bd);
    checks++; if (rv !== 32'h5) begin errors++; $display("FAIL wrap_alias got=%h exp=5", rv); end
  endtask

  task automatic test_both_high();
    run(2, 1'b1, 1'b0, 32'h20, 32'd0, 4'd0, dc, bc, rv, bd);
    run(2, 1'b1, 1'b1, 32'h30, 32'h7, 4'hF, dc, bc, rv, bd);
    checks++; if (dc != 4) begin errors++; $display("FAIL both_done_cycle got=%0d exp=4", dc); end
    checks++; if (rv !== 32'h11BB33DD) begin errors++; $display("FAIL both_rdata_held got=%h exp=11bb33dd", rv); end
    run(2, 1'b1, 1'b0, 32'h30, 32'd0, 4'd0, dc, bc, rv, bd);
    checks++; if (rv !== 32'h7) begin errors++; $display("FAIL both_stored got=%h exp=7", rv); end
  endtask

  task automatic test_latency0();
    run(0, 1'b0, 1'b1, 32'h8, 32'hCAFEF00D, 4'hF, dc, bc, rv, bd);
    checks++; if (dc != 2) begin errors++; $display("FAIL l0_done_cycle got=%0d exp=2", dc); end
    checks++; if (bc != 1) begin errors++; $display("FAIL l0_busy_cycles got=%0d exp=1", bc); end
    // Load held high through DONE and into the following IDLE cycle.
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 32'h8, 32'd0, 4'd0);
    #1;
    checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL l0_hold_c1_busy got=%b exp=1", busy0); end
    @(negedge clk); #1;
    checks++; if (done0 !== 1'b1) begin errors++; $display("FAIL l0_hold_c2_done got=%b exp=1", done0); end
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL l0_hold_c2_busy got=%b exp=0", busy0); end
    checks++; if (rdata0 !== 32'hCAFEF00D) begin errors++; $display("FAIL l0_hold_c2_data got=%h exp=cafef00d", rdata0); end
    @(negedge clk); #1;
    checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL l0_no_retrigger got=%b exp=0", done0); end
    checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL l0_idle_accept got=%b exp=1", busy0); end
    @(negedge clk); #1;
    checks++; if (done0 !== 1'b1) begin errors++; $display("FAIL l0_second_done got=%b exp=1", done0); end
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    @(negedge clk); #1;
    checks++; if ((busy0 | done0) !== 1'b0) begin errors++; $display("FAIL l0_quiet got=%b%b exp=00", busy0, done0); end
  endtask

  task automatic test_reset_mid_wait();
    run(3, 1'b0, 1'b1, 32'h40, 32'h0BADF00D, 4'hF, dc, bc, rv, bd);
    checks++; if (dc != 5) begin errors++; $display("FAIL l3_done_cycle got=%0d exp=5", dc); end
    checks++; if (bc != 4) begin errors++; $display("FAIL l3_busy_cycles got=%0d exp=4", bc); end
    run(3, 1'b1, 1'b0, 32'h40, 32'd0, 4'd0, dc, bc, rv, bd);
    checks++; if (rv !== 32'h0BADF00D) begin errors++; $display("FAIL l3_load got=%h exp=0badf00d", rv); end
    @(negedge clk);
    drive(3, 1'b0, 1'b1, 32'h40, 32'hFFFFFFFF, 4'hF);
    @(negedge clk);
    rst3 = 1'b1;
    @(negedge clk);
    rst3 = 1'b0;
    drive(3, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    #1;
    checks++; if (busy3 !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b exp=0", busy3); end
    checks++; if (rdata3 !== 32'd0) begin errors++; $display("FAIL midrst_rdata got=%h exp=0", rdata3); end
    for (int c = 0; c < 4; c++) begin
      checks++; if (done3 !== 1'b0) begin errors++; $display("FAIL midrst_no_done got=%b exp=0 cycle=%0d", done3, c); end
      @(negedge clk); #1;
    end
    run(3, 1'b1, 1'b0, 32'h40, 32'd0, 4'd0, dc, bc, rv, bd);
    checks++; if (rv !== 32'h0BADF00D) begin errors++; $display("FAIL midrst_store_dropped got=%h exp=0badf00d", rv); end
  endtask

  // Scenario sequence and summary.
  initial begin
    test_reset();
    test_store_load();
    test_byte_strobes();
    test_zero_strobe();
    test_wrap();
    test_both_high();
    test_latency0();
    test_reset_mid_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute time bound so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/dmem_stall_responder.md
Name: dmem_stall_responder

Overview:
- Multi-cycle data-memory responder on the M-stage side of the pipelined RISC-V core.
- Consumes the M-stage control and data from the E/M pipeline register: MemWriteM, a load indication, ALUResultM as the address, and WriteDataM.
- Performs the access with a configurable wait latency and raises a stall request to the hazard unit until load data is valid or the store is committed.
- Presents load data to the M/W register in the single cycle the stall drops.

Parameters:
- DEPTH, 1024, number of 32-bit words in the internal array (power of two).
- LATENCY, 2, number of WAIT cycles per access (0..15).
- AW, $clog2(DEPTH), word-index width.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- MemReadM  input  1  load request from M stage (ResultSrcM==2'b01)
- MemWriteM  input  1  store request from M stage
- ALUResultM  input  32  byte address
- WriteDataM  input  32  store data
- WriteStrbM  input  4  byte enables for store (bit i -> byte i)
- ReadDataM  output  32  load data, valid when MemDoneM=1
- MemBusyM  output  1  stall request to hazard unit (stall F/D/E/M, bubble W)
- MemDoneM  output  1  one-cycle pulse: access complete this cycle

Behaviour:
- Interface timing: one clock, clk; reset is synchronous and active-high.
- Reset values: state=IDLE, counter=0, ReadDataM=0, MemBusyM=0, MemDoneM=0. The memory array is not cleared.
- req = MemReadM | MemWriteM. If both are high, the access is a store; ReadDataM holds its old value.
- Requester holds inputs stable while MemBusyM=1. The responder captures address, data, strobes and type at acceptance and ignores input changes afterwards.
- Word index = ALUResultM[AW+1:2]. Bits [1:0] are ignored (no misalign trap). Upper bits are ignored, so addresses wrap modulo DEPTH words.
- FSM states: IDLE, WAIT, DONE.
  - IDLE: when req=0, MemBusyM=0 and state stays IDLE. When req=1, MemBusyM=1 (combinational from req), capture the request, counter<=LATENCY. Next state is WAIT if LATENCY>0, else DONE.
  - WAIT: MemBusyM=1; counter decrements each cycle. On the edge where counter==1, perform the access: a store writes the strobed bytes, a load registers the word into ReadDataM. Next state DONE.
  - LATENCY==0: the access is performed on the IDLE->DONE edge.
  - DONE: MemBusyM=0, MemDoneM=1, ReadDataM is valid, and the pipeline advances at the end of this cycle. The still-asserted req in DONE belongs to the finished instruction and must not retrigger. Next state is IDLE unconditionally.
- Latency: an accepted access stalls for LATENCY+1 cycles and completes in cycle LATENCY+2 counting the acceptance cycle as 1. Back-to-back accesses are therefore separated by at least one IDLE cycle.
- Read-after-write: a store commits on the edge into DONE, so a following load to the same word returns the new data.
- Store with WriteStrbM=0: full latency is still taken, the array is unchanged, and MemDoneM pulses.
- ReadDataM holds its value outside DONE and changes only on a load commit or reset.
- Reset in WAIT: return to IDLE, uncommitted store is dropped, MemBusyM=0 in the next cycle. Reset on the commit edge has priority, so no write occurs.

Test Plan:
- LATENCY=2. Store 0xDEADBEEF at 0x10 with strb=4'hF. Expect MemBusyM high in cycles 1-3 and MemDoneM in cycle 4. Then load 0x10: ReadDataM=0xDEADBEEF in its DONE cycle with MemBusyM=0.
- Byte strobes: word 0x20 holds 0x11223344. Store 0xAABBCCDD with strb=4'b0101. A subsequent load returns 0x11BB33DD.
- LATENCY=0. Load issued: MemBusyM=1 in cycle 1 only, MemDoneM=1 in cycle 2. Holding req high through DONE produces no second access: IDLE is entered, and a new access starts only if req is still high there.
- Wrap and alignment (DEPTH=1024): store 0x5 to 0x1003 (index 0). A load from 0x0 returns 0x5.
- Reset mid-WAIT (LATENCY=3). Store 0xFFFF_FFFF to 0x40 and assert reset in cycle 2. Expect MemBusyM=0 and ReadDataM=0 afterwards, and a later load of 0x40 returns the prior contents.
- MemReadM=MemWriteM=1 with WriteDataM=0x7: treated as a store, ReadDataM unchanged, word updated to 0x7.
